// File: rtl/ddd_chain_emu.sv
// Emulates the three-chip 3D3444 delay-chip daisy chain: shifts in the serial
// frame, decodes it on the address latch, and returns serial readback data.
module ddd_chain_emu #(
    parameter int NBITS = 60,
    parameter int SYNC  = 2
) (
    input  logic        clock,
    input  logic        global_reset,
    input  logic        ddd_sclk,
    input  logic        ddd_sdi,
    input  logic        ddd_adr_latch,
    output logic        ddd_sdo,
    output logic [11:0] oe,
    output logic [47:0] delay,
    output logic        latched,
    output logic        frame_err,
    output logic [6:0]  bit_cnt,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        LATCH = 2'b10
    } state_t;

    state_t state, state_nxt;

    // sdi needs no edge detector, so it has one stage fewer; the sampled
    // points of all three lines still line up.
    logic [SYNC:0]   sclk_q;
    logic [SYNC:0]   al_q;
    logic [SYNC-1:0] sdi_q;

    logic [NBITS-1:0] sr;
    logic [11:0]      oe_rx;
    logic [47:0]      delay_rx;

    logic sclk_s, sclk_d, al_s, al_d, sdi_s;
    logic sclk_rise, al_rise, accept;

    assign sclk_s    = sclk_q[SYNC-1];
    assign sclk_d    = sclk_q[SYNC];
    assign al_s      = al_q[SYNC-1];
    assign al_d      = al_q[SYNC];
    assign sdi_s     = sdi_q[SYNC-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign al_rise   = al_s & ~al_d;

    // A shift coinciding with the latch edge is dropped: the prior latch sample was low.
    assign accept = sclk_rise & al_s & al_d & (state != LATCH);
    assign busy   = (state != IDLE);

    // Three 20-bit groups, chip 2 first; each is oe high-to-low then four MSB-first delays.
    always_comb begin
        oe_rx    = '0;
        delay_rx = '0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 4; i++) begin
                oe_rx[4*c+3-i] = sr[NBITS-1-((2-c)*20+i)];
            end
            for (int j = 0; j < 4; j++) begin
                for (int b = 0; b < 4; b++) begin
                    delay_rx[4*(4*c+j)+3-b] = sr[NBITS-1-((2-c)*20+4+4*j+b)];
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (al_rise)     state_nxt = LATCH;
                else if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (al_rise) state_nxt = LATCH;
            end
            LATCH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (global_reset) begin
            state     <= IDLE;
            sclk_q    <= '0;
            al_q      <= '1;
            sdi_q     <= '0;
            sr        <= '0;
            ddd_sdo   <= 1'b0;
            oe        <= '0;
            delay     <= '0;
            latched   <= 1'b0;
            frame_err <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            state   <= state_nxt;
            sclk_q  <= {sclk_q[SYNC-1:0], ddd_sclk};
            al_q    <= {al_q[SYNC-1:0], ddd_adr_latch};
            sdi_q   <= {sdi_q[SYNC-2:0], ddd_sdi};
            ddd_sdo <= sr[NBITS-1];
            latched <= 1'b0;
            if (state == LATCH) begin
                bit_cnt <= '0;
                if (bit_cnt == 7'(NBITS)) begin
                    oe        <= oe_rx;
                    delay     <= delay_rx;
                    latched   <= 1'b1;
                    frame_err <= 1'b0;
                end else begin
                    frame_err <= 1'b1;
                end
            end else if (accept) begin
                sr <= {sr[NBITS-2:0], sdi_s};
                if (bit_cnt != 7'd127) bit_cnt <= bit_cnt + 7'd1;
            end
        end
    end

endmodule

// File: tb/tb_ddd_chain_emu.sv
// Scoreboard bench for ddd_chain_emu: latch results are queued by the driver
// and checked by a monitor when busy drops at the end of each LATCH.
module tb_ddd_chain_emu;

    logic        clock = 1'b0;
    logic        global_reset = 1'b1;
    logic        ddd_sclk = 1'b0;
    logic        ddd_sdi = 1'b0;
    logic        ddd_adr_latch = 1'b1;
    logic        ddd_sdo;
    logic [11:0] oe;
    logic [47:0] delay;
    logic        latched;
    logic        frame_err;
    logic [6:0]  bit_cnt;
    logic        busy;

    always #5 clock = ~clock;

    ddd_chain_emu #(.NBITS(60), .SYNC(2)) dut (
        .clock        (clock),
        .global_reset (global_reset),
        .ddd_sclk     (ddd_sclk),
        .ddd_sdi      (ddd_sdi),
        .ddd_adr_latch(ddd_adr_latch),
        .ddd_sdo      (ddd_sdo),
        .oe           (oe),
        .delay        (delay),
        .latched      (latched),
        .frame_err    (frame_err),
        .bit_cnt      (bit_cnt),
        .busy         (busy)
    );

    // Frames in send order, first bit in bit 59, derived by hand from oe/delay.
    localparam logic [59:0] FRAME_A = 60'hF89ABF4567F0123;
    localparam logic [11:0] OE_A    = 12'hFFF;
    localparam logic [47:0] DLY_A   = 48'hBA9876543210;
    localparam logic [59:0] FRAME_B = 60'hAE1F05C3D2CA5B4;
    localparam logic [11:0] OE_B    = 12'hA5C;
    localparam logic [47:0] DLY_B   = 48'h0F1E2D3C4B5A;

    typedef struct packed {
        logic [11:0] oe;
        logic [47:0] delay;
        logic        err;
        logic        lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   lat_cnt = 0;
    logic busy_prev = 1'b0;
    logic rst_at_edge = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clock) rst_at_edge = global_reset;

    always @(negedge clock) begin
        if (latched === 1'b1) lat_cnt++;
        if (busy_prev === 1'b1 && busy === 1'b0 && rst_at_edge === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_latch: got oe=%0h err=%0b, expected no latch", oe, frame_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("latch_oe", 64'(oe), 64'(e.oe));
                chk("latch_delay", 64'(delay), 64'(e.delay));
                chk("latch_frame_err", 64'(frame_err), 64'(e.err));
                chk("latch_pulse", 64'(latched), 64'(e.lat));
            end
        end
        busy_prev = busy;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b, input int half);
        ddd_sdi  = b;
        ddd_sclk = 1'b0;
        tick(half);
        ddd_sclk = 1'b1;
        tick(half);
    endtask

    task automatic send_frame(input logic [59:0] f, input int nbits);
        for (int k = 0; k < nbits; k++) send_bit((k < 60) ? f[59-k] : 1'b0, 1);
        ddd_sclk = 1'b0;
        tick(1);
    endtask

    task automatic pulse_latch(input logic [11:0] e_oe, input logic [47:0] e_dly,
                               input logic e_err, input logic e_lat);
        exp_t e;
        e.oe = e_oe; e.delay = e_dly; e.err = e_err; e.lat = e_lat;
        exp_q.push_back(e);
        ddd_sclk      = 1'b0;
        ddd_adr_latch = 1'b0;
        tick(1);
        ddd_adr_latch = 1'b1;
        tick(1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d latch results still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic [59:0] f;
        logic        sdo_before;

        tick(3);
        global_reset = 1'b0;
        tick(1);
        chk("reset_oe", 64'(oe), 64'h0);
        chk("reset_delay", 64'(delay), 64'h0);
        chk("reset_latched", 64'(latched), 64'h0);
        chk("reset_frame_err", 64'(frame_err), 64'h0);
        chk("reset_bit_cnt", 64'(bit_cnt), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_sdo", 64'(ddd_sdo), 64'h0);

        // Good frame
        send_frame(FRAME_A, 60);
        tick(6);
        chk("good_bit_cnt", 64'(bit_cnt), 64'd60);
        chk("good_busy", 64'(busy), 64'h1);
        pulse_latch(OE_A, DLY_A, 1'b0, 1'b1);
        drain("good_drain");
        chk("good_cnt_clear", 64'(bit_cnt), 64'h0);

        // Readback of the same frame with a slow serial clock
        f = FRAME_A;
        for (int k = 0; k < 60; k++) begin
            ddd_sdi  = f[59-k];
            ddd_sclk = 1'b0;
            chk($sformatf("readback_bit%0d", k), 64'(ddd_sdo), 64'(f[59-k]));
            tick(5);
            ddd_sclk = 1'b1;
            tick(5);
        end
        ddd_sclk = 1'b0;
        tick(6);
        chk("readback_oe", 64'(oe), 64'(OE_A));
        chk("readback_delay", 64'(delay), 64'(DLY_A));
        chk("readback_bit_cnt", 64'(bit_cnt), 64'd60);
        pulse_latch(OE_A, DLY_A, 1'b0, 1'b1);
        drain("relatch_drain");

        // Short and long frames, then a good frame B
        send_frame(FRAME_B, 59);
        tick(6);
        pulse_latch(OE_A, DLY_A, 1'b1, 1'b0);
        drain("short_drain");
        send_frame(FRAME_B, 61);
        tick(6);
        chk("long_bit_cnt", 64'(bit_cnt), 64'd61);
        pulse_latch(OE_A, DLY_A, 1'b1, 1'b0);
        drain("long_drain");
        send_frame(FRAME_B, 60);
        tick(6);
        pulse_latch(OE_B, DLY_B, 1'b0, 1'b1);
        drain("goodb_drain");

        // Serial clocks while the address latch is held low are ignored
        send_frame(FRAME_B, 30);
        tick(6);
        chk("gated_pre_cnt", 64'(bit_cnt), 64'd30);
        sdo_before    = ddd_sdo;
        ddd_adr_latch = 1'b0;
        tick(4);
        for (int k = 0; k < 5; k++) send_bit(~sdo_before, 1);
        ddd_sclk = 1'b0;
        tick(6);
        chk("gated_bit_cnt", 64'(bit_cnt), 64'd30);
        chk("gated_sdo", 64'(ddd_sdo), 64'(sdo_before));
        exp_q.push_back('{oe: OE_B, delay: DLY_B, err: 1'b1, lat: 1'b0});
        ddd_adr_latch = 1'b1;
        tick(1);
        drain("gated_drain");

        // Reset in the middle of a frame
        send_frame(FRAME_A, 30);
        tick(6);
        chk("midrst_pre_cnt", 64'(bit_cnt), 64'd30);
        global_reset = 1'b1;
        tick(1);
        chk("midrst_oe", 64'(oe), 64'h0);
        chk("midrst_delay", 64'(delay), 64'h0);
        chk("midrst_frame_err", 64'(frame_err), 64'h0);
        chk("midrst_bit_cnt", 64'(bit_cnt), 64'h0);
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_sdo", 64'(ddd_sdo), 64'h0);
        chk("midrst_latched", 64'(latched), 64'h0);
        global_reset = 1'b0;
        tick(2);
        send_frame(FRAME_A, 60);
        tick(6);
        pulse_latch(OE_A, DLY_A, 1'b0, 1'b1);
        drain("postrst_drain");

        // Bit counter saturation
        send_frame(FRAME_A, 130);
        tick(6);
        chk("sat_bit_cnt", 64'(bit_cnt), 64'd127);
        pulse_latch(OE_A, DLY_A, 1'b1, 1'b0);
        drain("sat_drain");
        chk("sat_cnt_clear", 64'(bit_cnt), 64'h0);

        tick(4);
        chk("latched_pulses", 64'(lat_cnt), 64'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
